// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencing controller: states,
// opcodes, ALU operation codes and datapath mux selects.
package multicycle_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUSEL_W = 6;
    localparam int unsigned SRCB_W   = 2;
    localparam int unsigned PCSRC_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        RST_S    = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        WB_R     = 4'd4,
        EXEC_I   = 4'd5,
        WB_I     = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        WB_MEM   = 4'd9,
        MEM_WR   = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12,
        ILLEGAL  = 4'd13
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;

    localparam logic [ALUSEL_W-1:0] ALU_ADD = 6'h20;
    localparam logic [ALUSEL_W-1:0] ALU_SUB = 6'h22;
    localparam logic [ALUSEL_W-1:0] ALU_AND = 6'h24;
    localparam logic [ALUSEL_W-1:0] ALU_OR  = 6'h25;
    localparam logic [ALUSEL_W-1:0] ALU_SLT = 6'h2A;

    typedef enum logic [SRCB_W-1:0] {
        SRCB_REGB    = 2'd0,
        SRCB_FOUR    = 2'd1,
        SRCB_IMM     = 2'd2,
        SRCB_IMM_SH2 = 2'd3
    } alu_src_b_t;

    typedef enum logic [PCSRC_W-1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_ALUOUT = 2'd1,
        PCSRC_JUMP   = 2'd2
    } pc_src_t;

    // R-type funct codes pass straight through as ALUsel, so legal = ALU codes
    function automatic logic is_legal_funct(input logic [FUNCT_W-1:0] f);
        return (f == ALU_ADD) || (f == ALU_SUB) || (f == ALU_AND) ||
               (f == ALU_OR)  || (f == ALU_SLT);
    endfunction

    function automatic logic [ALUSEL_W-1:0] imm_alu_sel(input logic [OPCODE_W-1:0] op);
        logic [ALUSEL_W-1:0] sel;
        case (op)
            OP_SLTI: sel = ALU_SLT;
            OP_ANDI: sel = ALU_AND;
            OP_ORI:  sel = ALU_OR;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Memory-request watchdog: counts consecutive stalled request cycles and
// flags expiry on the cycle the limit is hit; TIMEOUT_CYCLES=0 disables it.
module mem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    input  logic mem_ready,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // A ready in the limit cycle completes the access and suppresses expiry
    assign expire_c = (TIMEOUT_CYCLES != 0) && mem_req && !mem_ready && (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!mem_req || mem_ready || expire_c || (TIMEOUT_CYCLES == 0)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencing controller: one instruction in flight, outputs
// decoded from state and IR fields. Optional perf counters: MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [PCSRC_W-1:0]  pc_src,
    output logic                alu_src_a,
    output logic [SRCB_W-1:0]   alu_src_b,
    output logic [ALUSEL_W-1:0] ALUsel,
    output logic                regsel,
    output logic                datasource,
    output logic                reg_write,
    output logic                illegal,
    output logic                bus_err
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]         instr_count,
    output logic [31:0]         cycle_count
`endif
);

    state_t state;
    state_t next_state;
    logic   expire_c;
    logic   bus_err_q;

    // Memory handshake decodes from state alone, keeping the watchdog loop-free
    assign mem_req = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign mem_we  = (state == MEM_WR);
    assign iord    = (state == MEM_RD) || (state == MEM_WR);
    assign illegal = (state == ILLEGAL);
    assign bus_err = bus_err_q;

    mem_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_mem_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_ready (mem_ready),
        .expire_c  (expire_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_S;
            bus_err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (expire_c) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Next state and datapath controls
    always_comb begin
        next_state = state;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REGB;
        ALUsel     = '0;
        regsel     = 1'b0;
        datasource = 1'b0;
        reg_write  = 1'b0;
        case (state)
            RST_S: next_state = FETCH;
            FETCH: begin
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    ALUsel     = ALU_ADD;
                    next_state = DECODE;
                end else if (expire_c) begin
                    next_state = ILLEGAL;
                end
            end
            DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                ALUsel    = ALU_ADD;
                case (opcode)
                    OP_RTYPE:                         next_state = is_legal_funct(funct) ? EXEC_R : ILLEGAL;
                    OP_LW, OP_SW:                     next_state = MEM_ADDR;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: next_state = EXEC_I;
                    OP_BEQ:                           next_state = BRANCH;
                    OP_J:                             next_state = JUMP;
                    default:                          next_state = ILLEGAL;
                endcase
            end
            EXEC_R: begin
                alu_src_a  = 1'b1;
                ALUsel     = funct;
                next_state = WB_R;
            end
            WB_R: begin
                reg_write  = 1'b1;
                regsel     = 1'b1;
                next_state = FETCH;
            end
            EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                ALUsel     = imm_alu_sel(opcode);
                next_state = WB_I;
            end
            WB_I: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                ALUsel     = ALU_ADD;
                next_state = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                if (mem_ready) begin
                    next_state = WB_MEM;
                end else if (expire_c) begin
                    next_state = ILLEGAL;
                end
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                datasource = 1'b1;
                next_state = FETCH;
            end
            MEM_WR: begin
                if (mem_ready) begin
                    next_state = FETCH;
                end else if (expire_c) begin
                    next_state = ILLEGAL;
                end
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                ALUsel     = ALU_SUB;
                pc_src     = PCSRC_ALUOUT;
                pc_write   = zero;
                next_state = FETCH;
            end
            JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_write   = 1'b1;
                next_state = FETCH;
            end
            ILLEGAL: next_state = ILLEGAL;
            default: next_state = RST_S;
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            if (ir_write) begin
                instr_count <= instr_count + 32'd1;
            end
            if ((state != RST_S) && (state != ILLEGAL)) begin
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a random
// instruction stream checked against an instruction-level expectation model.
module tb_multicycle_ctrl;

    localparam int unsigned TO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] ALUsel;
    logic       regsel, datasource, reg_write, illegal, bus_err;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instr_count, cycle_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ALUsel     (ALUsel),
        .regsel     (regsel),
        .datasource (datasource),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .bus_err    (bus_err)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .instr_count(instr_count),
        .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req, we, iord, irw, pcw;
        logic [1:0] pcs;
        logic       a;
        logic [1:0] b;
        logic [5:0] alu;
        logic       rs, ds, rw, ill, berr;
    } smp_t;

    typedef struct packed {
        logic [7:0] n_req, n_we, n_iord, n_irw, n_pcw, n_rw;
        logic [1:0] pcw_src;
        logic       wr_rs, wr_ds;
        logic [5:0] exec_alu;
        logic [1:0] exec_b;
        logic       ill, berr;
    } summ_t;

    smp_t cur;
    assign cur = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, ALUsel, regsel, datasource, reg_write, illegal, bus_err};

    smp_t trace[$];

    function automatic bit legal_fn(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction

    function automatic bit is_iop(input logic [5:0] op);
        return op inside {6'h08, 6'h0A, 6'h0C, 6'h0D};
    endfunction

    // Cycles an instruction occupies from its first FETCH cycle (illegal: +1 ILLEGAL cycle)
    function automatic int exp_len(input logic [5:0] op, input logic [5:0] fn, input int f, input int m);
        if ((op == 6'h00 && legal_fn(fn)) || is_iop(op)) return f + 4;
        if (op == 6'h23) return f + m + 5;
        if (op == 6'h2B) return f + m + 4;
        if (op == 6'h04 || op == 6'h02) return f + 3;
        return f + 3;
    endfunction

    function automatic summ_t expect_summ(input logic [5:0] op, input logic [5:0] fn,
                                          input int f, input int m, input logic z);
        summ_t s;
        bit r, lw, sw, im, beq, j;
        r   = (op == 6'h00) && legal_fn(fn);
        lw  = (op == 6'h23);
        sw  = (op == 6'h2B);
        im  = is_iop(op);
        beq = (op == 6'h04);
        j   = (op == 6'h02);
        s = '0;
        s.n_req  = 8'(f + 1 + ((lw || sw) ? m + 1 : 0));
        s.n_we   = 8'(sw ? m + 1 : 0);
        s.n_iord = 8'((lw || sw) ? m + 1 : 0);
        s.n_irw  = 8'd1;
        s.n_pcw  = 8'(1 + ((beq && z) ? 1 : 0) + (j ? 1 : 0));
        s.n_rw   = 8'((r || im || lw) ? 1 : 0);
        s.pcw_src = j ? 2'd2 : ((beq && z) ? 2'd1 : 2'd0);
        s.wr_rs  = r;
        s.wr_ds  = lw;
        if (r) s.exec_alu = fn;
        else if (op == 6'h08) s.exec_alu = 6'h20;
        else if (op == 6'h0A) s.exec_alu = 6'h2A;
        else if (op == 6'h0C) s.exec_alu = 6'h24;
        else if (op == 6'h0D) s.exec_alu = 6'h25;
        else if (lw || sw) s.exec_alu = 6'h20;
        else if (beq) s.exec_alu = 6'h22;
        s.exec_b = (im || lw || sw) ? 2'd2 : 2'd0;
        s.ill  = !(r || lw || sw || im || beq || j);
        s.berr = 1'b0;
        return s;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Drives one instruction starting in a FETCH cycle; records every cycle
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int f,
                             input int m, input logic z, output summ_t s);
        int  len;
        bit  is_mem;
        int  n_req, n_we, n_iord, n_irw, n_pcw, n_rw;
        trace.delete();
        opcode = op;
        funct  = fn;
        zero   = z;
        len    = exp_len(op, fn, f, m);
        is_mem = (op == 6'h23) || (op == 6'h2B);
        for (int c = 0; c < len; c++) begin
            mem_ready = (c == f) || (is_mem && (c == f + 3 + m));
            @(negedge clk);
            trace.push_back(cur);
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        s = '0;
        n_req = 0; n_we = 0; n_iord = 0; n_irw = 0; n_pcw = 0; n_rw = 0;
        foreach (trace[i]) begin
            if (trace[i].req)  n_req++;
            if (trace[i].we)   n_we++;
            if (trace[i].iord) n_iord++;
            if (trace[i].irw)  n_irw++;
            if (trace[i].pcw) begin n_pcw++; s.pcw_src = trace[i].pcs; end
            if (trace[i].rw)  begin n_rw++; s.wr_rs = trace[i].rs; s.wr_ds = trace[i].ds; end
            if (trace[i].a)   begin s.exec_alu = trace[i].alu; s.exec_b = trace[i].b; end
            s.ill  = s.ill  | trace[i].ill;
            s.berr = s.berr | trace[i].berr;
        end
        s.n_req = 8'(n_req); s.n_we = 8'(n_we); s.n_iord = 8'(n_iord);
        s.n_irw = 8'(n_irw); s.n_pcw = 8'(n_pcw); s.n_rw = 8'(n_rw);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (cur !== '0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", cur); end
`ifdef MULTICYCLE_CTRL_PERF_EN
        vectors++;
        if ({instr_count, cycle_count} !== 64'd0) begin
            miscompares++; $display("FAIL reset_perf: got %h/%h want 0/0", instr_count, cycle_count);
        end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (cur !== '0) begin miscompares++; $display("FAIL rst_s_outputs: got %h want 0", cur); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if ({cur.req, cur.iord, cur.irw} !== 3'b100) begin
            miscompares++; $display("FAIL first_fetch: got req/iord/irw=%b want 100", {cur.req, cur.iord, cur.irw});
        end
    endtask

    task automatic test_rtype();
        summ_t s, e;
        do_reset();
        run_instr(6'h00, 6'h20, 0, 0, 1'b0, s);
        e = expect_summ(6'h00, 6'h20, 0, 0, 1'b0);
        vectors++;
        if (s !== e) begin miscompares++; $display("FAIL rtype_summary: got %h want %h", s, e); end
        vectors++;
        if ({trace[0].irw, trace[0].pcw, trace[0].b, trace[0].alu} !== {1'b1, 1'b1, 2'd1, 6'h20}) begin
            miscompares++; $display("FAIL rtype_fetch: got %h want %h", {trace[0].irw, trace[0].pcw, trace[0].b, trace[0].alu}, {1'b1, 1'b1, 2'd1, 6'h20});
        end
        vectors++;
        if ({trace[1].a, trace[1].b, trace[1].alu, trace[1].pcw} !== {1'b0, 2'd3, 6'h20, 1'b0}) begin
            miscompares++; $display("FAIL rtype_decode: got %h want %h", {trace[1].a, trace[1].b, trace[1].alu, trace[1].pcw}, {1'b0, 2'd3, 6'h20, 1'b0});
        end
        vectors++;
        if ({trace[3].rw, trace[3].rs, trace[3].ds} !== 3'b110) begin
            miscompares++; $display("FAIL rtype_wb: got %b want 110", {trace[3].rw, trace[3].rs, trace[3].ds});
        end
`ifdef MULTICYCLE_CTRL_PERF_EN
        vectors++;
        if ({instr_count, cycle_count} !== {32'd1, 32'd4}) begin
            miscompares++; $display("FAIL perf_rtype: got %0d/%0d want 1/4", instr_count, cycle_count);
        end
`endif
    endtask

    task automatic test_lw_stall();
        summ_t s, e;
        int bad;
        do_reset();
        run_instr(6'h23, 6'h00, 3, 3, 1'b0, s);
        e = expect_summ(6'h23, 6'h00, 3, 3, 1'b0);
        vectors++;
        if (s !== e) begin miscompares++; $display("FAIL lw_summary: got %h want %h", s, e); end
        bad = 0;
        for (int i = 0; i < 4; i++) if (!trace[i].req || trace[i].iord || (trace[i].irw != (i == 3))) bad++;
        for (int i = 6; i < 10; i++) if (!trace[i].req || !trace[i].iord || trace[i].we) bad++;
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL lw_req_hold: got %0d bad cycles want 0", bad); end
        vectors++;
        if ({trace[10].rw, trace[10].rs, trace[10].ds, trace[10].req} !== 4'b1010) begin
            miscompares++; $display("FAIL lw_wb_mem: got %b want 1010", {trace[10].rw, trace[10].rs, trace[10].ds, trace[10].req});
        end
    endtask

    task automatic test_branch();
        summ_t s, e;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            run_instr(6'h04, 6'h00, 0, 0, (k == 0), s);
            e = expect_summ(6'h04, 6'h00, 0, 0, (k == 0));
            vectors++;
            if (s !== e) begin miscompares++; $display("FAIL beq_summary_z%0d: got %h want %h", (k == 0), s, e); end
            vectors++;
            if ({trace[2].pcw, trace[2].pcs} !== {(k == 0) ? 1'b1 : 1'b0, 2'd1}) begin
                miscompares++; $display("FAIL beq_branch_z%0d: got pcw/src=%b want %b", (k == 0), {trace[2].pcw, trace[2].pcs}, {(k == 0) ? 1'b1 : 1'b0, 2'd1});
            end
        end
    endtask

    task automatic test_illegal();
        summ_t s, e;
        int bad;
        logic [5:0] ops[2];
        logic [5:0] fns[2];
        ops[0] = 6'h3F; fns[0] = 6'h20;
        ops[1] = 6'h00; fns[1] = 6'h01;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            run_instr(ops[k], fns[k], 0, 0, 1'b0, s);
            e = expect_summ(ops[k], fns[k], 0, 0, 1'b0);
            vectors++;
            if (s !== e) begin miscompares++; $display("FAIL illegal_summary_%0d: got %h want %h", k, s, e); end
            vectors++;
            if ({trace[1].ill, trace[2].ill} !== 2'b01) begin
                miscompares++; $display("FAIL illegal_timing_%0d: got %b want 01", k, {trace[1].ill, trace[2].ill});
            end
            bad = 0;
            for (int c = 0; c < 6; c++) begin
                mem_ready = 1'($urandom_range(0, 1));
                zero = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (!cur.ill || cur.req || cur.pcw || cur.irw || cur.rw || cur.berr) bad++;
                @(posedge clk); #1;
            end
            mem_ready = 1'b0;
            vectors++;
            if (bad !== 0) begin miscompares++; $display("FAIL illegal_sticky_%0d: got %0d bad cycles want 0", k, bad); end
        end
        do_reset();
        vectors++;
        if (cur.ill !== 1'b0) begin miscompares++; $display("FAIL illegal_cleared: got %b want 0", cur.ill); end
    endtask

    task automatic test_watchdog();
        summ_t s, e;
        int bad;
        do_reset();
        opcode = 6'h00; funct = 6'h20;
        bad = 0;
        for (int c = 0; c < int'(TO); c++) begin
            @(negedge clk);
            if (!cur.req || cur.berr || cur.ill) bad++;
            @(posedge clk); #1;
        end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL wdog_wait: got %0d bad cycles want 0", bad); end
        @(negedge clk);
        vectors++;
        if ({cur.berr, cur.ill, cur.req} !== 3'b110) begin
            miscompares++; $display("FAIL wdog_expire: got berr/ill/req=%b want 110", {cur.berr, cur.ill, cur.req});
        end
        for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
        vectors++;
        if ({cur.berr, cur.ill} !== 2'b11) begin
            miscompares++; $display("FAIL wdog_sticky: got %b want 11", {cur.berr, cur.ill});
        end
        do_reset();
        vectors++;
        if (cur.berr !== 1'b0) begin miscompares++; $display("FAIL wdog_reset: got %b want 0", cur.berr); end
        run_instr(6'h00, 6'h20, int'(TO) - 1, 0, 1'b0, s);
        e = expect_summ(6'h00, 6'h20, int'(TO) - 1, 0, 1'b0);
        vectors++;
        if (s !== e) begin miscompares++; $display("FAIL wdog_ready_at_limit: got %h want %h", s, e); end
    endtask

    task automatic test_async_reset();
        do_reset();
        opcode = 6'h2B; funct = 6'h00;
        for (int c = 0; c < 3; c++) begin
            mem_ready = (c == 0);
            @(negedge clk);
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cur.req, cur.we, cur.iord} !== 3'b111) begin
            miscompares++; $display("FAIL memwr_req: got %b want 111", {cur.req, cur.we, cur.iord});
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (cur !== '0) begin miscompares++; $display("FAIL async_reset: got %h want 0", cur); end
`ifdef MULTICYCLE_CTRL_PERF_EN
        vectors++;
        if ({instr_count, cycle_count} !== 64'd0) begin
            miscompares++; $display("FAIL async_perf: got %0d/%0d want 0/0", instr_count, cycle_count);
        end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (cur !== '0) begin miscompares++; $display("FAIL restart_rst_s: got %h want 0", cur); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if ({cur.req, cur.iord, cur.we} !== 3'b100) begin
            miscompares++; $display("FAIL restart_fetch: got %b want 100", {cur.req, cur.iord, cur.we});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        summ_t s, e;
        logic [5:0] op, fn;
        logic [5:0] iops[4];
        logic       z;
        int         f, m;
        iops[0] = 6'h08; iops[1] = 6'h0A; iops[2] = 6'h0C; iops[3] = 6'h0D;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            fn = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 7))
                0: begin op = 6'h00; fn = 6'h20 + 6'(2 * $urandom_range(0, 2)); if ($urandom_range(0, 2) == 0) fn = 6'h2A; end
                1: begin op = 6'h00; while (legal_fn(fn)) fn = 6'($urandom_range(0, 63)); end
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = iops[$urandom_range(0, 3)];
                5: op = 6'h04;
                6: op = 6'h02;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (op inside {6'h00, 6'h23, 6'h2B, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h04, 6'h02})
                        op = 6'($urandom_range(0, 63));
                end
            endcase
            f = $urandom_range(0, 4);
            m = $urandom_range(0, 4);
            z = 1'($urandom_range(0, 1));
            run_instr(op, fn, f, m, z, s);
            e = expect_summ(op, fn, f, m, z);
            vectors++;
            if (s !== e) begin
                miscompares++;
                $display("FAIL random_%0d op=%h fn=%h f=%0d m=%0d z=%b: got %h want %h", n, op, fn, f, m, z, s, e);
            end
            if (e.ill) do_reset();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL tb_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branch();
        test_illegal();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
